// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel-tick enable in, sync/blank/coordinate/strobe outputs back.
interface video_timing_gen_if #(
    parameter int unsigned COORD_W = 11
);
    logic               enable;
    logic               HS;
    logic               VS;
    logic               blank_n;
    logic [COORD_W-1:0] pixelX;
    logic [COORD_W-1:0] pixelY;
    logic               coord_valid;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  enable,
        output HS, VS, blank_n, pixelX, pixelY, coord_valid, line_start, frame_start
    );

    modport slave (
        output enable,
        input  HS, VS, blank_n, pixelX, pixelY, coord_valid, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync/back/active/front ordering, registered coordinates
// that lead HS/VS/blank_n by PIPE_LEAD enabled clocks.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned PIPE_LEAD = 0,
    parameter int unsigned COORD_W   = 11
) (
    input  logic               vga_clk,
    input  logic               resetN,
    video_timing_gen_if.master vt
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_CW    = $clog2(H_TOTAL);
    localparam int unsigned V_CW    = $clog2(V_TOTAL);

    localparam logic [H_CW-1:0] H_LAST      = H_CW'(H_TOTAL - 1);
    localparam logic [H_CW-1:0] H_SYNC_LEN  = H_CW'(H_SYNC);
    localparam logic [H_CW-1:0] H_VIS_FIRST = H_CW'(H_SYNC + H_BACK);
    localparam logic [H_CW-1:0] H_VIS_LAST  = H_CW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [V_CW-1:0] V_LAST      = V_CW'(V_TOTAL - 1);
    localparam logic [V_CW-1:0] V_SYNC_LEN  = V_CW'(V_SYNC);
    localparam logic [V_CW-1:0] V_VIS_FIRST = V_CW'(V_SYNC + V_BACK);
    localparam logic [V_CW-1:0] V_VIS_LAST  = V_CW'(V_SYNC + V_BACK + V_ACTIVE - 1);

    // Delay-line entry layout: {HS level, VS level, blank_n}
    localparam logic [2:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

    logic [H_CW-1:0]    h_cnt;
    logic [V_CW-1:0]    v_cnt;
    logic               visible;
    logic               first_col;
    logic [H_CW-1:0]    x_off;
    logic [V_CW-1:0]    y_off;
    logic [2:0]         raw_sync;
    logic [2:0]         sync_pipe [PIPE_LEAD+1];
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               coord_valid;
    logic               line_start;
    logic               frame_start;

    always_comb begin
        visible   = (h_cnt >= H_VIS_FIRST) && (h_cnt <= H_VIS_LAST) &&
                    (v_cnt >= V_VIS_FIRST) && (v_cnt <= V_VIS_LAST);
        first_col = visible && (h_cnt == H_VIS_FIRST);
        x_off     = h_cnt - H_VIS_FIRST;
        y_off     = v_cnt - V_VIS_FIRST;
        raw_sync  = {(h_cnt < H_SYNC_LEN) ? HS_POL : ~HS_POL,
                     (v_cnt < V_SYNC_LEN) ? VS_POL : ~VS_POL,
                     visible};
    end

    always_ff @(posedge vga_clk) begin
        if (!resetN) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            coord_valid <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int unsigned i = 0; i <= PIPE_LEAD; i++) begin
                sync_pipe[i] <= SYNC_IDLE;
            end
        end else if (vt.enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // Out-of-region offsets would be wrapped values, so force zero there
            pixel_x     <= visible ? COORD_W'(x_off) : '0;
            pixel_y     <= visible ? COORD_W'(y_off) : '0;
            coord_valid <= visible;
            line_start  <= first_col;
            frame_start <= first_col && (v_cnt == V_VIS_FIRST);
            sync_pipe[0] <= raw_sync;
            for (int unsigned i = 1; i <= PIPE_LEAD; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign vt.HS          = sync_pipe[PIPE_LEAD][2];
    assign vt.VS          = sync_pipe[PIPE_LEAD][1];
    assign vt.blank_n     = sync_pipe[PIPE_LEAD][0];
    assign vt.pixelX      = pixel_x;
    assign vt.pixelY      = pixel_y;
    assign vt.coord_valid = coord_valid;
    assign vt.line_start  = line_start;
    assign vt.frame_start = frame_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 800x525 instance and a small PIPE_LEAD=3 instance
// checked every cycle against a position-based model, plus phase tables and corner sequences.
module tb_video_timing_gen;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic        cv;
        logic        ls;
        logic        fs;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    typedef struct {
        int   d;
        exp_t e;
    } sb_t;

    typedef struct {
        int ht, vt, hsy, hst, ha, vsy, vst, va, lead;
        bit hpol, vpol;
    } cfg_t;

    // Phase vectors: inputs (reset, enable mode, length) and expected per-phase counts
    // mode 0: enable=1, 1: enable toggles starting at 1, 2: enable=0
    typedef struct {
        string name;
        bit    rst;
        int    mode;
        int    cycles;
        int    e_hs_a;
        int    e_bl_a;
        int    e_fs_b;
        int    e_vs_b;
    } vec_t;

    logic clk;
    logic resetN;
    logic en;

    video_timing_gen_if #(.COORD_W(11)) ifa ();
    video_timing_gen_if #(.COORD_W(11)) ifb ();
    assign ifa.enable = en;
    assign ifb.enable = en;

    video_timing_gen #(.PIPE_LEAD(0)) dut_a (
        .vga_clk (clk),
        .resetN  (resetN),
        .vt      (ifa)
    );

    video_timing_gen #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .HS_POL (1'b1), .VS_POL (1'b0), .PIPE_LEAD (3), .COORD_W (11)
    ) dut_b (
        .vga_clk (clk),
        .resetN  (resetN),
        .vt      (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cfg_t cfg [2];
    int   n_pos [2];
    sb_t  sbq [$];
    vec_t tbl [4];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_hs_a, m_bl_a, m_fs_b, m_vs_b;

    function automatic bit in_vis(input int d, input int h, input int v);
        return h >= cfg[d].hst && h < cfg[d].hst + cfg[d].ha &&
               v >= cfg[d].vst && v < cfg[d].vst + cfg[d].va;
    endfunction

    // Expected outputs after n enabled clocks since reset: coordinates show counter position n-1,
    // syncs show position n-1-lead; positions before 0 read as idle.
    function automatic exp_t model(input int d, input int n);
        exp_t e;
        int   p, h, v;
        e    = '0;
        e.hs = ~cfg[d].hpol;
        e.vs = ~cfg[d].vpol;
        if (n >= 1) begin
            p = n - 1;
            h = p % cfg[d].ht;
            v = (p / cfg[d].ht) % cfg[d].vt;
            if (in_vis(d, h, v)) begin
                e.cv = 1'b1;
                e.x  = 11'(h - cfg[d].hst);
                e.y  = 11'(v - cfg[d].vst);
                e.ls = (h == cfg[d].hst);
                e.fs = (h == cfg[d].hst) && (v == cfg[d].vst);
            end
        end
        if (n - 1 - cfg[d].lead >= 0) begin
            p    = n - 1 - cfg[d].lead;
            h    = p % cfg[d].ht;
            v    = (p / cfg[d].ht) % cfg[d].vt;
            e.hs = (h < cfg[d].hsy) ? cfg[d].hpol : ~cfg[d].hpol;
            e.vs = (v < cfg[d].vsy) ? cfg[d].vpol : ~cfg[d].vpol;
            e.bl = in_vis(d, h, v);
        end
        return e;
    endfunction

    function automatic exp_t get_act(input int d);
        exp_t a;
        if (d == 0) a = {ifa.HS, ifa.VS, ifa.blank_n, ifa.coord_valid, ifa.line_start,
                         ifa.frame_start, ifa.pixelX, ifa.pixelY};
        else        a = {ifb.HS, ifb.VS, ifb.blank_n, ifb.coord_valid, ifb.line_start,
                         ifb.frame_start, ifb.pixelX, ifb.pixelY};
        return a;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, queue the model result, compare at the next negedge
    task automatic step(input bit rn, input bit e);
        sb_t  s;
        exp_t a;
        resetN = rn;
        en     = e;
        for (int d = 0; d < 2; d++) begin
            if (!rn)    n_pos[d] = 0;
            else if (e) n_pos[d]++;
            s.d = d;
            s.e = model(d, n_pos[d]);
            sbq.push_back(s);
        end
        @(posedge clk);
        @(negedge clk);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            a = get_act(s.d);
            n_cmp++;
            if (a !== s.e) begin
                n_bad++;
                $display("FAIL sb_dut%0d pos=%0d: got %h expected %h", s.d, n_pos[s.d], a, s.e);
            end
        end
        m_hs_a += (ifa.HS == 1'b0) ? 1 : 0;
        m_bl_a += ifa.blank_n ? 1 : 0;
        m_fs_b += ifb.frame_start ? 1 : 0;
        m_vs_b += (ifb.VS == 1'b0) ? 1 : 0;
    endtask

    initial begin
        int  t_cv, t_bl, fa, fb;
        bit  pcv, pbl, end_pending, end_done, found;

        cfg[0] = '{ht: 800, vt: 525, hsy: 96, hst: 144, ha: 640, vsy: 2, vst: 35, va: 480,
                   lead: 0, hpol: 1'b0, vpol: 1'b0};
        cfg[1] = '{ht: 15, vt: 10, hsy: 3, hst: 5, ha: 8, vsy: 2, vst: 4, va: 5,
                   lead: 3, hpol: 1'b1, vpol: 1'b0};
        n_pos[0] = 0;
        n_pos[1] = 0;

        tbl[0] = '{"reset",   1'b1, 0, 3,     0,    0,    0,   0};
        tbl[1] = '{"run",     1'b0, 0, 28800, 3456, 640,  192, 5760};
        tbl[2] = '{"toggle",  1'b0, 1, 1600,  192,  1280, 10,  360};
        tbl[3] = '{"freeze",  1'b0, 2, 50,    0,    0,    0,   0};

        resetN = 1'b0;
        en     = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            m_hs_a = 0; m_bl_a = 0; m_fs_b = 0; m_vs_b = 0;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                step(!tbl[i].rst, tbl[i].mode == 0 ? 1'b1 :
                                  tbl[i].mode == 1 ? ((c % 2) == 0) : 1'b0);
            end
            check({tbl[i].name, "_hs_low_a"}, m_hs_a, tbl[i].e_hs_a);
            check({tbl[i].name, "_blank_a"},  m_bl_a, tbl[i].e_bl_a);
            check({tbl[i].name, "_fs_b"},     m_fs_b, tbl[i].e_fs_b);
            check({tbl[i].name, "_vs_low_b"}, m_vs_b, tbl[i].e_vs_b);
        end

        // Lead of coord_valid over blank_n, and pixelX dropping to 0 after the last column
        t_cv = -1; t_bl = -1; end_pending = 0; end_done = 0;
        pcv = ifb.coord_valid;
        pbl = ifb.blank_n;
        for (int k = 1; k <= 200 && (t_bl < 0 || !end_done); k++) begin
            step(1'b1, 1'b1);
            if (!pcv && ifb.coord_valid && t_cv < 0) t_cv = k;
            if (!pbl && ifb.blank_n && t_bl < 0) t_bl = k;
            if (end_pending) begin
                check("x_after_last", int'(ifb.pixelX), 0);
                check("cv_after_last", int'(ifb.coord_valid), 0);
                end_pending = 0;
                end_done    = 1;
            end
            if (!end_done && ifb.coord_valid && ifb.pixelX == 11'd7) end_pending = 1;
            pcv = ifb.coord_valid;
            pbl = ifb.blank_n;
        end
        check("cv_rise_seen", (t_cv >= 0) ? 1 : 0, 1);
        check("cv_to_blank_lead", t_bl - t_cv, 3);
        check("last_col_seen", int'(end_done), 1);

        // Mid-frame reset at a visible pixel, then time to the first frame_start
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            step(1'b1, 1'b1);
            if (ifb.coord_valid && ifb.pixelX == 11'd4 && ifb.pixelY == 11'd2) found = 1;
        end
        check("mid_pixel_found", int'(found), 1);
        step(1'b0, 1'b1);
        check("rst_hs_a", int'(ifa.HS), 1);
        check("rst_cv_b", int'(ifb.coord_valid), 0);
        fa = 0; fb = 0;
        for (int k = 1; k <= 30000 && fa == 0; k++) begin
            step(1'b1, 1'b1);
            if (fb == 0 && ifb.frame_start) fb = k;
            if (ifa.frame_start) fa = k;
        end
        check("first_fs_b", fb, 66);
        check("first_fs_a", fa, 28145);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
